config_chain_loader: RTL and testbench

//  Sequences the serial configuration chain through every switch block.
//  - Accepts a bitstream from the host as WORD_WIDTH-bit words over a valid/ready handshake.
//  - Serialises those words into the chain.
//  - Counts exactly CHAIN_LENGTH shift pulses, then reports completion.
//  - Sits between the host/bitstream interface and the head of the fabric config chain.

---
 rtl/config_chain_loader.sv | 176 +++++++++++++++++
 tb/tb_config_chain_loader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/config_chain_loader.sv
// Host-to-fabric configuration chain loader: accepts bitstream words and shifts exactly CHAIN_LENGTH bits, LSB first.
// Optional CRC-16-CCITT trailer check is enabled by defining CONFIG_CRC_CHECK_EN.
module config_chain_loader #(
    parameter int CHAIN_LENGTH = 48,
    parameter int WORD_WIDTH   = 8
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset_n,
    input  logic                  i_Start,
    input  logic                  i_WordValid,
    output logic                  o_WordReady,
    input  logic [WORD_WIDTH-1:0] i_Word,
    output logic                  o_ConfigShiftEnable,
    output logic                  o_ConfigShiftData,
    output logic                  o_Busy,
    output logic                  o_Done,
    output logic                  o_Error
);

    localparam int BIT_CNT_W  = $clog2(CHAIN_LENGTH + 1);
    localparam int WORD_CNT_W = $clog2(WORD_WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        CRC_LOAD,
        CHECK,
        DONE
    } state_t;

    state_t                  stateReg;
    state_t                  stateNext;
    logic [WORD_WIDTH-1:0]   shiftReg;
    logic [BIT_CNT_W-1:0]    bitCount;
    logic [WORD_CNT_W-1:0]   wordBitCount;
    logic                    doneReg;
    logic                    wordReady;
    logic                    shiftEnable;
    logic                    lastChainBit;
    logic                    lastWordBit;

    assign lastChainBit = (bitCount == BIT_CNT_W'(CHAIN_LENGTH - 1));
    assign lastWordBit  = (wordBitCount == WORD_CNT_W'(WORD_WIDTH - 1));

`ifdef CONFIG_CRC_CHECK_EN
    localparam int CRC_WORDS  = (16 + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int CRC_RX_W   = CRC_WORDS * WORD_WIDTH;
    localparam int CRC_CNT_W  = $clog2(CRC_WORDS + 1);

    logic [15:0]           crcReg;
    logic [CRC_RX_W-1:0]   crcRxReg;
    logic [CRC_CNT_W-1:0]  crcWordCount;
    logic                  errorReg;
    logic                  crcFeedback;
    logic                  lastCrcWord;

    assign crcFeedback = crcReg[15] ^ shiftReg[0];
    assign lastCrcWord = (crcWordCount == CRC_CNT_W'(CRC_WORDS - 1));
    assign o_Error     = errorReg;
`else
    assign o_Error     = 1'b0;
`endif

    always_comb begin
        stateNext   = stateReg;
        wordReady   = 1'b0;
        shiftEnable = 1'b0;
        case (stateReg)
            IDLE: begin
                if (i_Start) stateNext = LOAD;
            end
            LOAD: begin
                wordReady = 1'b1;
                if (i_WordValid) stateNext = SHIFT;
            end
            SHIFT: begin
                shiftEnable = 1'b1;
                if (lastChainBit) begin
`ifdef CONFIG_CRC_CHECK_EN
                    stateNext = CRC_LOAD;
`else
                    stateNext = DONE;
`endif
                end else if (lastWordBit) begin
                    stateNext = LOAD;
                end
            end
`ifdef CONFIG_CRC_CHECK_EN
            CRC_LOAD: begin
                wordReady = 1'b1;
                if (i_WordValid && lastCrcWord) stateNext = CHECK;
            end
            CHECK: begin
                stateNext = DONE;
            end
`endif
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            stateReg     <= IDLE;
            shiftReg     <= '0;
            bitCount     <= '0;
            wordBitCount <= '0;
            doneReg      <= 1'b0;
`ifdef CONFIG_CRC_CHECK_EN
            crcReg       <= 16'hFFFF;
            crcRxReg     <= '0;
            crcWordCount <= '0;
            errorReg     <= 1'b0;
`endif
        end else begin
            stateReg <= stateNext;
            case (stateReg)
                IDLE: begin
                    if (i_Start) begin
                        doneReg      <= 1'b0;
                        bitCount     <= '0;
                        wordBitCount <= '0;
`ifdef CONFIG_CRC_CHECK_EN
                        crcReg       <= 16'hFFFF;
                        crcWordCount <= '0;
                        errorReg     <= 1'b0;
`endif
                    end
                end
                LOAD: begin
                    if (i_WordValid) begin
                        shiftReg     <= i_Word;
                        wordBitCount <= '0;
                    end
                end
                SHIFT: begin
                    shiftReg     <= shiftReg >> 1;
                    bitCount     <= bitCount + BIT_CNT_W'(1);
                    wordBitCount <= wordBitCount + WORD_CNT_W'(1);
`ifdef CONFIG_CRC_CHECK_EN
                    crcReg       <= {crcReg[14:0], 1'b0} ^ (crcFeedback ? 16'h1021 : 16'h0000);
`endif
                end
`ifdef CONFIG_CRC_CHECK_EN
                CRC_LOAD: begin
                    // Least-significant word arrives first, so new words enter at the top.
                    if (i_WordValid) begin
                        crcRxReg     <= (crcRxReg >> WORD_WIDTH) |
                                        (CRC_RX_W'(i_Word) << (CRC_RX_W - WORD_WIDTH));
                        crcWordCount <= crcWordCount + CRC_CNT_W'(1);
                    end
                end
                CHECK: begin
                    errorReg <= (crcRxReg[15:0] != crcReg);
                end
`endif
                default: begin
                end
            endcase
            // Done is a sticky level that survives the return to IDLE.
            if ((stateReg != DONE) && (stateNext == DONE)) doneReg <= 1'b1;
        end
    end

    assign o_WordReady         = wordReady;
    assign o_ConfigShiftEnable = shiftEnable;
    assign o_ConfigShiftData   = shiftReg[0];
    assign o_Busy              = (stateReg != IDLE) && (stateReg != DONE);
    assign o_Done              = doneReg;

endmodule

// File: tb/tb_config_chain_loader.sv
// Directed bench for config_chain_loader: a 48-bit chain instance and a 12-bit chain instance.
// Define CONFIG_CRC_CHECK_EN to also exercise the CRC trailer.
module tb_config_chain_loader;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstN;
    logic       start48, start12;
    logic       valid;
    logic [7:0] word;

    logic ready48, en48, data48, busy48, done48, err48;
    logic ready12, en12, data12, busy12, done12, err12;

    config_chain_loader #(.CHAIN_LENGTH(48), .WORD_WIDTH(8)) dut48 (
        .i_Clock(clk), .i_Reset_n(rstN), .i_Start(start48), .i_WordValid(valid),
        .o_WordReady(ready48), .i_Word(word), .o_ConfigShiftEnable(en48),
        .o_ConfigShiftData(data48), .o_Busy(busy48), .o_Done(done48), .o_Error(err48)
    );

    config_chain_loader #(.CHAIN_LENGTH(12), .WORD_WIDTH(8)) dut12 (
        .i_Clock(clk), .i_Reset_n(rstN), .i_Start(start12), .i_WordValid(valid),
        .o_WordReady(ready12), .i_Word(word), .o_ConfigShiftEnable(en12),
        .o_ConfigShiftData(data12), .o_Busy(busy12), .o_Done(done12), .o_Error(err12)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Chain capture: sampled mid-cycle, records what each enabled edge shifts in.
    logic        monClr;
    int          enCnt48, enCnt12;
    logic [63:0] seq48, seq12;

    always @(negedge clk) begin
        if (monClr) begin
            enCnt48 <= 0; seq48 <= '0;
            enCnt12 <= 0; seq12 <= '0;
        end else begin
            if (en48) begin
                if (enCnt48 < 64) seq48[enCnt48[5:0]] <= data48;
                enCnt48 <= enCnt48 + 1;
            end
            if (en12) begin
                if (enCnt12 < 64) seq12[enCnt12[5:0]] <= data12;
                enCnt12 <= enCnt12 + 1;
            end
        end
    end

    function automatic logic [15:0] crcModel(input logic [63:0] bits, input int n);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            fb = c[15] ^ bits[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    // Runs one load; doneCycle counts edges after the edge that samples i_Start.
    task automatic runLoad(input bit sel, input logic [63:0] data, input int nWords,
                           input int stallAfter, input int stallCycles,
                           input int startPulseAt, input int abortAt,
                           output int doneCycle, output int accepts, output bit stallEnSeen);
        int   cyc;
        int   stall;
        bit   acc;
        logic rdy;
        doneCycle   = -1;
        accepts     = 0;
        stallEnSeen = 1'b0;
        stall       = 0;
        @(posedge clk); #1;
        monClr = 1'b1;
        if (sel) start12 = 1'b1; else start48 = 1'b1;
        @(posedge clk); #1;
        monClr  = 1'b0;
        start12 = 1'b0;
        start48 = 1'b0;
        valid   = 1'b1;
        word    = data[7:0];
        cyc     = 0;
        while (doneCycle == -1 && cyc < 300) begin
            rdy = sel ? ready12 : ready48;
            acc = valid && rdy;
            if (!valid && stall > 0 && rdy) begin
                stall--;
                if (sel ? en12 : en48) stallEnSeen = 1'b1;
            end
            @(posedge clk);
            cyc++;
            #1;
            if (acc) begin
                accepts++;
                if (accepts < nWords) begin
                    word = data[accepts*8 +: 8];
                    if (accepts == stallAfter && stallCycles > 0) begin
                        valid = 1'b0;
                        stall = stallCycles;
                    end
                end else begin
                    valid = 1'b0;
                end
            end else if (!valid && stall == 0 && accepts < nWords) begin
                valid = 1'b1;
            end
            start48 = !sel && (cyc == startPulseAt);
            start12 = sel && (cyc == startPulseAt);
            if (cyc == abortAt) begin
                check("T4 enable before reset", {63'd0, en48}, 64'd1);
                rstN = 1'b0;
                #1;
                check("T4 outputs in reset",
                      {58'd0, ready48, en48, data48, busy48, done48, err48}, 64'd0);
                doneCycle = -2;
            end else if (sel ? done12 : done48) begin
                doneCycle = cyc;
            end
        end
        valid   = 1'b0;
        start48 = 1'b0;
        start12 = 1'b0;
    endtask

    localparam logic [63:0] T1_DATA = 64'h0000_0605_0403_0201;
    localparam logic [63:0] T2_DATA = 64'h0000_0000_0000_F3FF;

    initial begin
        int          dc, acc;
        bit          se;
        logic [63:0] d;
        logic [15:0] crc;
        int          t2Done;

        rstN = 1'b0; start48 = 1'b0; start12 = 1'b0; valid = 1'b0; word = '0; monClr = 1'b1;
        #12;
        check("reset outputs 48",
              {58'd0, ready48, en48, data48, busy48, done48, err48}, 64'd0);
        check("reset outputs 12",
              {58'd0, ready12, en12, data12, busy12, done12, err12}, 64'd0);
        @(posedge clk); #1 rstN = 1'b1;

        // T1: six words, valid held high
        d = T1_DATA;
`ifdef CONFIG_CRC_CHECK_EN
        crc = crcModel(T1_DATA, 48);
        d[63:48] = crc;
        runLoad(1'b0, d, 8, 0, 0, -1, -1, dc, acc, se);
        check("T1 accepts", acc, 8);
`else
        crc = 16'h0;
        runLoad(1'b0, d, 6, 0, 0, -1, -1, dc, acc, se);
        check("T1 done cycle", dc, 54);
        check("T1 accepts", acc, 6);
`endif
        check("T1 enable count", enCnt48, 48);
        check("T1 shifted bits", seq48, T1_DATA);
        check("T1 busy/done/err", {61'd0, busy48, done48, err48}, 64'b010);
        repeat (3) @(posedge clk);
        #1 check("T1 done holds in idle", {62'd0, busy48, done48}, 64'b01);

        // T2: 12-bit chain, surplus nibble of the second word dropped
        d = T2_DATA;
`ifdef CONFIG_CRC_CHECK_EN
        d[31:16] = crcModel(64'h3FF, 12);
        runLoad(1'b1, d, 4, 0, 0, -1, -1, dc, acc, se);
        t2Done = 17;
`else
        runLoad(1'b1, d, 2, 0, 0, -1, -1, dc, acc, se);
        t2Done = 14;
`endif
        check("T2 done cycle", dc, t2Done);
        check("T2 enable count", enCnt12, 12);
        check("T2 shifted bits", seq12, 64'h3FF);
        check("T2 error", {63'd0, err12}, 64'd0);

        // T3: valid withheld for 10 ready cycles after word 2
        d = T1_DATA;
`ifdef CONFIG_CRC_CHECK_EN
        d[63:48] = crc;
        runLoad(1'b0, d, 8, 2, 10, -1, -1, dc, acc, se);
`else
        runLoad(1'b0, d, 6, 2, 10, -1, -1, dc, acc, se);
        check("T3 done cycle", dc, 64);
`endif
        check("T3 enable during stall", {63'd0, se}, 64'd0);
        check("T3 enable count", enCnt48, 48);
        check("T3 shifted bits", seq48, T1_DATA);

        // T4: reset in the middle of word 3, then a clean reload
        runLoad(1'b0, d, 6, 0, 0, -1, 23, dc, acc, se);
        check("T4 aborted", dc, -2);
        #20;
        @(posedge clk); #1 rstN = 1'b1;
`ifdef CONFIG_CRC_CHECK_EN
        runLoad(1'b0, d, 8, 0, 0, -1, -1, dc, acc, se);
        check("T4 reload error", {63'd0, err48}, 64'd0);
`else
        runLoad(1'b0, d, 6, 0, 0, -1, -1, dc, acc, se);
        check("T4 reload done cycle", dc, 54);
`endif
        check("T4 reload enable count", enCnt48, 48);
        check("T4 reload shifted bits", seq48, T1_DATA);

        // T5: start pulsed mid-load is ignored
`ifdef CONFIG_CRC_CHECK_EN
        runLoad(1'b0, d, 8, 0, 0, 30, -1, dc, acc, se);
        check("T5 accepts", acc, 8);
`else
        runLoad(1'b0, d, 6, 0, 0, 30, -1, dc, acc, se);
        check("T5 done cycle", dc, 54);
        check("T5 accepts", acc, 6);
`endif
        check("T5 enable count", enCnt48, 48);
        check("T5 shifted bits", seq48, T1_DATA);

`ifdef CONFIG_CRC_CHECK_EN
        // T6: correct CRC then CRC with bit 0 flipped
        check("T6 good crc done/err", {62'd0, done48, err48}, 64'b10);
        d[48] = ~d[48];
        runLoad(1'b0, d, 8, 0, 0, -1, -1, dc, acc, se);
        check("T6 bad crc done/err", {62'd0, done48, err48}, 64'b11);
        check("T6 bad crc enable count", enCnt48, 48);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
